// File: rtl/sim_monitor_pkg.sv
// Shared types and defaults for the simulation result monitor.
// Banner names exist only for simulation builds.
package sim_monitor_pkg;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_PASS    = 3'd1,
        ST_FAIL    = 3'd2,
        ST_TIMEOUT = 3'd3,
        ST_HANG    = 3'd4
    } mon_state_e;

    localparam int unsigned DEF_DONE_REG = 26;
    localparam int unsigned DEF_RES_REG  = 27;
    localparam int unsigned DEF_DONE_VAL = 1;
    localparam int unsigned DEF_PASS_VAL = 1;

`ifndef SYNTHESIS
    // Lower-case words keep the banner distinguishable from checker output.
    function automatic string state_name(mon_state_e s);
        case (s)
            ST_RUN:     return "run";
            ST_PASS:    return "pass";
            ST_FAIL:    return "nopass";
            ST_TIMEOUT: return "timeout";
            ST_HANG:    return "hang";
            default:    return "unknown";
        endcase
    endfunction
`endif

endpackage

// File: rtl/sim_result_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear and freeze.
// Priority: clear > freeze > enable; it sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic         frz_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] r_cnt;
    logic         w_sat;

    assign w_sat = &r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i && !frz_i && !w_sat) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/sim_result_monitor.sv
// Test-result monitor snooping the GPR write port: pass/fail signature,
// run-timeout and no-retire watchdogs, frozen cycle count, sticky status.
module sim_result_monitor
    import sim_monitor_pkg::*;
#(
    parameter int unsigned    DW          = 32,
    parameter int unsigned    AW          = 5,
    parameter int unsigned    DONE_REG    = DEF_DONE_REG,
    parameter int unsigned    RES_REG     = DEF_RES_REG,
    parameter logic [DW-1:0]  DONE_VAL    = DW'(DEF_DONE_VAL),
    parameter logic [DW-1:0]  PASS_VAL    = DW'(DEF_PASS_VAL),
    parameter int unsigned    CW          = 32,
    parameter logic [CW-1:0]  TIMEOUT_CYC = '0,
    parameter logic [CW-1:0]  HANG_CYC    = '0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          halted_i,
    input  logic          gpr_we_i,
    input  logic [AW-1:0] gpr_waddr_i,
    input  logic [DW-1:0] gpr_wdata_i,
    output logic          done_o,
    output logic          pass_o,
    output logic          fail_o,
    output logic          timeout_o,
    output logic          hang_o,
    output logic [DW-1:0] result_o,
    output logic [CW-1:0] end_cycles_o,
    output mon_state_e    dbg_state_o
);

    if (DONE_REG == 0) begin : g_chk_done_nonzero
        $error("sim_result_monitor: DONE_REG must not be x0");
    end
    if (DONE_REG == RES_REG) begin : g_chk_done_ne_res
        $error("sim_result_monitor: DONE_REG and RES_REG must differ");
    end
    if (DONE_REG >= (1 << AW) || RES_REG >= (1 << AW)) begin : g_chk_range
        $error("sim_result_monitor: register index out of GPR range");
    end

    localparam logic [AW-1:0] DONE_A    = AW'(DONE_REG);
    localparam logic [AW-1:0] RES_A     = AW'(RES_REG);
    localparam bit            TO_EN     = (TIMEOUT_CYC != '0);
    localparam bit            HANG_EN   = (HANG_CYC != '0);
    localparam logic [CW-1:0] TO_LAST   = TIMEOUT_CYC - CW'(1);
    localparam logic [CW-1:0] HANG_LAST = HANG_CYC - CW'(1);

    mon_state_e    r_state;
    mon_state_e    w_state_nxt;
    logic [DW-1:0] r_res_shadow;
    logic [CW-1:0] w_run_cnt;
    logic [CW-1:0] w_idle_cnt;
    logic          w_run;
    logic          w_end_evt;
    logic          w_to_evt;
    logic          w_hang_evt;
    logic          w_res_wr;

    assign w_run     = (r_state == ST_RUN);
    assign w_res_wr  = w_run && gpr_we_i && (gpr_waddr_i == RES_A) && (gpr_waddr_i != '0);
    assign w_end_evt = w_run && gpr_we_i && (gpr_waddr_i == DONE_A) && (gpr_wdata_i == DONE_VAL);
    // Both watchdogs are frozen while the core sits in debug halt.
    assign w_to_evt   = TO_EN && w_run && !halted_i && (w_run_cnt == TO_LAST);
    assign w_hang_evt = HANG_EN && w_run && !halted_i && !gpr_we_i && (w_idle_cnt == HANG_LAST);

    always_comb begin
        w_state_nxt = r_state;
        if (clear_i) begin
            w_state_nxt = ST_RUN;
        end else if (w_run) begin
            if (w_end_evt) begin
                w_state_nxt = (r_res_shadow == PASS_VAL) ? ST_PASS : ST_FAIL;
            end else if (w_to_evt) begin
                w_state_nxt = ST_TIMEOUT;
            end else if (w_hang_evt) begin
                w_state_nxt = ST_HANG;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_res_shadow <= '0;
        end else if (clear_i) begin
            r_res_shadow <= '0;
        end else if (w_res_wr) begin
            r_res_shadow <= gpr_wdata_i;
        end
    end

    // The terminating cycle is not counted, so end_cycles equals the run
    // count seen when the end/timeout condition was evaluated.
    sat_counter #(.W(CW)) u_run_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (w_run && (w_state_nxt == ST_RUN) && !halted_i),
        .clr_i  (clear_i),
        .frz_i  (!w_run),
        .cnt_o  (w_run_cnt)
    );

    sat_counter #(.W(CW)) u_idle_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (w_run && !halted_i),
        .clr_i  (clear_i || gpr_we_i),
        .frz_i  (!w_run),
        .cnt_o  (w_idle_cnt)
    );

    assign pass_o       = (r_state == ST_PASS);
    assign fail_o       = (r_state == ST_FAIL);
    assign timeout_o    = (r_state == ST_TIMEOUT);
    assign hang_o       = (r_state == ST_HANG);
    assign done_o       = pass_o | fail_o | timeout_o | hang_o;
    assign result_o     = r_res_shadow;
    assign end_cycles_o = w_run_cnt;
    assign dbg_state_o  = r_state;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni && w_run && (w_state_nxt != ST_RUN)) begin
            $display("[sim_result_monitor] state=%s result=0x%0h cycles=%0d",
                     state_name(w_state_nxt), r_res_shadow, w_run_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_sim_result_monitor.sv
// Directed bench for sim_result_monitor: a per-cycle vector table on the
// default build plus hand sequences for the watchdog and reset corners.
module tb_sim_result_monitor;
    import sim_monitor_pkg::*;

    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_PASS = 5'b11000;
    localparam logic [4:0] F_FAIL = 5'b10100;
    localparam logic [4:0] F_TO   = 5'b10010;
    localparam logic [4:0] F_HANG = 5'b10001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear, halted, we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    logic        o0_done, o0_pass, o0_fail, o0_to, o0_hang;
    logic        o1_done, o1_pass, o1_fail, o1_to, o1_hang;
    logic        o2_done, o2_pass, o2_fail, o2_to, o2_hang;
    logic [31:0] o0_res, o1_res, o2_res, o0_cyc, o1_cyc, o2_cyc;
    mon_state_e  dbg0, dbg1, dbg2;
    logic [4:0]  f0, f1, f2;

    assign f0 = {o0_done, o0_pass, o0_fail, o0_to, o0_hang};
    assign f1 = {o1_done, o1_pass, o1_fail, o1_to, o1_hang};
    assign f2 = {o2_done, o2_pass, o2_fail, o2_to, o2_hang};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sim_result_monitor u_dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .halted_i(halted),
        .gpr_we_i(we), .gpr_waddr_i(waddr), .gpr_wdata_i(wdata),
        .done_o(o0_done), .pass_o(o0_pass), .fail_o(o0_fail), .timeout_o(o0_to),
        .hang_o(o0_hang), .result_o(o0_res), .end_cycles_o(o0_cyc), .dbg_state_o(dbg0)
    );

    sim_result_monitor #(.TIMEOUT_CYC(32'd50)) u_dut_to (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .halted_i(halted),
        .gpr_we_i(we), .gpr_waddr_i(waddr), .gpr_wdata_i(wdata),
        .done_o(o1_done), .pass_o(o1_pass), .fail_o(o1_fail), .timeout_o(o1_to),
        .hang_o(o1_hang), .result_o(o1_res), .end_cycles_o(o1_cyc), .dbg_state_o(dbg1)
    );

    sim_result_monitor #(.HANG_CYC(32'd8)) u_dut_hg (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .halted_i(halted),
        .gpr_we_i(we), .gpr_waddr_i(waddr), .gpr_wdata_i(wdata),
        .done_o(o2_done), .pass_o(o2_pass), .fail_o(o2_fail), .timeout_o(o2_to),
        .hang_o(o2_hang), .result_o(o2_res), .end_cycles_o(o2_cyc), .dbg_state_o(dbg2)
    );

    typedef struct {
        logic        clr;
        logic        hlt;
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
        logic [4:0]  e_flags;
        logic [31:0] e_res;
        logic [31:0] e_cyc;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input logic c, input logic h, input logic w, input logic [4:0] a,
                           input logic [31:0] d, input logic [4:0] ef, input logic [31:0] er,
                           input logic [31:0] ec);
        vec_t v;
        v.clr = c; v.hlt = h; v.we = w; v.a = a; v.d = d;
        v.e_flags = ef; v.e_res = er; v.e_cyc = ec;
        vq.push_back(v);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled at the same point.
    task automatic step(input logic c, input logic h, input logic w, input logic [4:0] a,
                        input logic [31:0] d);
        clear = c; halted = h; we = w; waddr = a; wdata = d;
        @(posedge clk);
        #1;
        clear = 1'b0; halted = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    endtask

    task automatic idle(input int n, input logic h);
        for (int i = 0; i < n; i++) step(1'b0, h, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clear = 1'b0; halted = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Default build: DONE=x26/1, PASS=1, watchdogs off. Expected run count after each row.
        add_vec(0, 0, 0, 5'd0,  32'h0,  F_NONE, 32'h0,  32'd1);
        add_vec(0, 0, 1, 5'd27, 32'h13, F_NONE, 32'h13, 32'd2);
        add_vec(0, 0, 1, 5'd0,  32'h5,  F_NONE, 32'h13, 32'd3);
        add_vec(0, 0, 1, 5'd26, 32'h2,  F_NONE, 32'h13, 32'd4);
        add_vec(0, 1, 0, 5'd0,  32'h0,  F_NONE, 32'h13, 32'd4);
        add_vec(0, 0, 1, 5'd26, 32'h1,  F_FAIL, 32'h13, 32'd4);
        add_vec(0, 0, 1, 5'd27, 32'h1,  F_FAIL, 32'h13, 32'd4);
        add_vec(0, 0, 1, 5'd26, 32'h1,  F_FAIL, 32'h13, 32'd4);
        add_vec(1, 0, 1, 5'd27, 32'h1,  F_NONE, 32'h0,  32'd0);
        add_vec(0, 0, 1, 5'd27, 32'h1,  F_NONE, 32'h1,  32'd1);
        add_vec(0, 0, 1, 5'd26, 32'h1,  F_PASS, 32'h1,  32'd1);
        add_vec(0, 0, 0, 5'd0,  32'h0,  F_PASS, 32'h1,  32'd1);
        add_vec(1, 0, 1, 5'd26, 32'h1,  F_NONE, 32'h0,  32'd0);
        add_vec(0, 0, 0, 5'd0,  32'h0,  F_NONE, 32'h0,  32'd1);
        add_vec(0, 0, 1, 5'd26, 32'h1,  F_FAIL, 32'h0,  32'd1);

        do_reset();
        check("reset.flags0", f0, F_NONE);
        check("reset.flags1", f1, F_NONE);
        check("reset.flags2", f2, F_NONE);
        check("reset.res0", o0_res, 32'h0);
        check("reset.cyc0", o0_cyc, 32'h0);
        check("reset.state0", dbg0, ST_RUN);

        foreach (vq[i]) begin
            step(vq[i].clr, vq[i].hlt, vq[i].we, vq[i].a, vq[i].d);
            check($sformatf("vec%0d.flags", i), f0, vq[i].e_flags);
            check($sformatf("vec%0d.res", i), o0_res, vq[i].e_res);
            check($sformatf("vec%0d.cyc", i), o0_cyc, vq[i].e_cyc);
        end

        // Pass at cycle 100 with result 1.
        do_reset();
        for (int i = 0; i < 100; i++) begin
            if (i == 5) step(0, 0, 1, 5'd27, 32'h1);
            else        step(0, 0, 0, 5'd0, 32'h0);
        end
        check("t1.pre_flags", f0, F_NONE);
        check("t1.pre_cyc", o0_cyc, 32'd100);
        step(0, 0, 1, 5'd26, 32'h1);
        check("t1.flags", f0, F_PASS);
        check("t1.cyc", o0_cyc, 32'd100);
        check("t1.res", o0_res, 32'h1);
        check("t1.state", dbg0, ST_PASS);
        idle(3, 1'b0);
        check("t1.cyc_frozen", o0_cyc, 32'd100);

        // Clear in PASS restarts monitoring.
        step(1, 0, 0, 5'd0, 32'h0);
        check("t6.clr_flags", f0, F_NONE);
        check("t6.clr_res", o0_res, 32'h0);
        check("t6.clr_cyc", o0_cyc, 32'd0);
        idle(1, 1'b0);
        check("t6.restart_cyc", o0_cyc, 32'd1);

        // Timeout at 50 run cycles, halted during cycles 10..19.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            step(0, (i >= 10 && i <= 19), 0, 5'd0, 32'h0);
            if (i == 9)  check("t3.halt_start_cyc", o1_cyc, 32'd10);
            if (i == 19) check("t3.halt_end_cyc", o1_cyc, 32'd10);
            if (i == 58) begin
                check("t3.pre_flags", f1, F_NONE);
                check("t3.pre_cyc", o1_cyc, 32'd49);
            end
        end
        check("t3.flags", f1, F_TO);
        check("t3.cyc", o1_cyc, 32'd49);

        // End condition on the expiry cycle wins over the timeout.
        do_reset();
        for (int i = 0; i < 49; i++) begin
            if (i == 3) step(0, 0, 1, 5'd27, 32'h1);
            else        step(0, 0, 0, 5'd0, 32'h0);
        end
        check("t5.pre_cyc", o1_cyc, 32'd49);
        step(0, 0, 1, 5'd26, 32'h1);
        check("t5.flags", f1, F_PASS);
        check("t5.cyc", o1_cyc, 32'd49);

        // Hang after 8 idle cycles once writes stop after cycle 20.
        do_reset();
        for (int i = 0; i <= 20; i++) step(0, 0, 1, 5'd5, 32'(i));
        idle(7, 1'b0);
        check("t4.pre_flags", f2, F_NONE);
        idle(1, 1'b0);
        check("t4.flags", f2, F_HANG);
        check("t4.cyc", o2_cyc, 32'd28);

        // Halted core never hangs; the count resumes after release.
        do_reset();
        for (int i = 0; i <= 20; i++) step(0, 0, 1, 5'd5, 32'(i));
        idle(30, 1'b1);
        check("t4h.halted_flags", f2, F_NONE);
        check("t4h.halted_cyc", o2_cyc, 32'd21);
        idle(7, 1'b0);
        check("t4h.resume_pre", f2, F_NONE);
        idle(1, 1'b0);
        check("t4h.resume_flags", f2, F_HANG);

        // Async reset mid-run drops outputs without a clock edge.
        do_reset();
        step(0, 0, 1, 5'd27, 32'h7);
        step(0, 0, 1, 5'd26, 32'h1);
        check("t6r.pre_flags", f0, F_FAIL);
        check("t6r.pre_res", o0_res, 32'h7);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6r.async_flags", f0, F_NONE);
        check("t6r.async_res", o0_res, 32'h0);
        check("t6r.async_cyc", o0_cyc, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2, 1'b0);
        check("t6r.after_cyc", o0_cyc, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
